// File: rtl/alu_seq_if.sv
// alu_seq_if: start/done operand and result bundle for alu_seq.
// master drives operands and start; slave returns busy/done/result/flags.
interface alu_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] dst;
    logic [WIDTH-1:0] src;
    logic [3:0]       oper;
    logic [3:0]       func;
    logic [4:0]       condIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       condOut;
    logic             condWr;

    modport master (
        output start, dst, src, oper, func, condIn,
        input  busy, done, result, condOut, condWr
    );

    modport slave (
        input  start, dst, src, oper, func, condIn,
        output busy, done, result, condOut, condWr
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with start/done handshake.
// Define ALU_DIV_EN to build the iterative DIVU/REMU divider.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ALU = 4'b0000;
    localparam logic [3:0] OP_SHF = 4'b1000;

    localparam logic [3:0] F_AND  = 4'b0001;
    localparam logic [3:0] F_OR   = 4'b0010;
    localparam logic [3:0] F_XOR  = 4'b0011;
    localparam logic [3:0] F_ADD  = 4'b0101;
    localparam logic [3:0] F_ADDC = 4'b0111;
    localparam logic [3:0] F_SUB  = 4'b1001;
    localparam logic [3:0] F_SUBC = 4'b1010;
    localparam logic [3:0] F_CMP  = 4'b1011;
    localparam logic [3:0] F_MOV  = 4'b1101;
    localparam logic [3:0] F_MUL  = 4'b1110;
    localparam logic [3:0] F_LSH  = 4'b0100;
    localparam logic [3:0] F_ASH  = 4'b0110;
`ifdef ALU_DIV_EN
    localparam logic [3:0] F_REMU = 4'b1100;
    localparam logic [3:0] F_DIVU = 4'b1111;
`endif

    // flag bit positions within {N,Z,F,L,C}
    localparam int FN = 4;
    localparam int FZ = 3;
    localparam int FF = 2;
    localparam int FL = 1;
    localparam int FC = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_n;

    logic [WIDTH-1:0] a, b;
    logic [4:0]       ci;
    logic             accept;

    assign a      = bus.dst;
    assign b      = bus.src;
    assign ci     = bus.condIn;
    assign accept = (state_q == S_IDLE) && bus.start;

    logic             cy;
    logic [WIDTH:0]   sum, dif;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] shl, shr_l, shr_a;

    logic [WIDTH-1:0] sc_res;
    logic [4:0]       sc_flg;
    logic             sc_wr;
    logic             go_mul, go_div;

    logic [WIDTH-1:0] result_q;
    logic [4:0]       flg_q, cin_q;
    logic             wr_q;
    logic [CW-1:0]    cnt_q;
    logic             last;

    logic [WIDTH-1:0] mcd_q, mpl_q, acc_q, acc_nx;

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             rsel_q;
    logic [WIDTH:0]   rtry;
    logic             rfit;
    logic [WIDTH-1:0] rsub, rem_nx, quo_nx;
    logic             dz;

    assign rtry   = {rem_q, quo_q[WIDTH-1]};
    assign rfit   = rtry >= {1'b0, dvs_q};
    assign rsub   = rtry[WIDTH-1:0] - dvs_q;
    assign rem_nx = rfit ? rsub : rtry[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], rfit};
    assign dz     = (dvs_q == '0);
`endif

    assign last   = (cnt_q == '0);
    assign acc_nx = acc_q + (mpl_q[0] ? mcd_q : '0);

    // signed shift distance: src[4:0] two's complement, magnitude up to 16
    assign shamt = b[4] ? (~b[4:0]) + 5'd1 : b[4:0];
    assign shl   = a << shamt;
    assign shr_l = a >> shamt;
    assign shr_a = $signed(a) >>> shamt;

    // add/subtract with optional carry/borrow from the incoming C flag
    always_comb begin
        cy  = ((bus.func == F_ADDC) || (bus.func == F_SUBC)) && ci[FC];
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cy};
        dif = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cy};
    end

    // decode single-cycle result/flags and detect iterative ops
    always_comb begin
        sc_res = a;
        sc_flg = ci;
        sc_wr  = 1'b0;
        go_mul = 1'b0;
        go_div = 1'b0;
        case (bus.oper)
            OP_ALU: begin
                case (bus.func)
                    F_AND: sc_res = a & b;
                    F_OR:  sc_res = a | b;
                    F_XOR: sc_res = a ^ b;
                    F_MOV: sc_res = b;
                    F_ADD, F_ADDC: begin
                        sc_res     = sum[WIDTH-1:0];
                        sc_wr      = 1'b1;
                        sc_flg[FC] = sum[WIDTH];
                        sc_flg[FF] = (a[WIDTH-1] == b[WIDTH-1]) &&
                                     (sum[WIDTH-1] != a[WIDTH-1]);
                    end
                    F_SUB, F_SUBC: begin
                        sc_res     = dif[WIDTH-1:0];
                        sc_wr      = 1'b1;
                        sc_flg[FC] = dif[WIDTH];
                        sc_flg[FF] = (a[WIDTH-1] != b[WIDTH-1]) &&
                                     (dif[WIDTH-1] != a[WIDTH-1]);
                    end
                    F_CMP: begin
                        sc_wr      = 1'b1;
                        sc_flg[FZ] = (a == b);
                        sc_flg[FL] = (a < b);
                        sc_flg[FN] = ($signed(a) < $signed(b));
                    end
                    F_MUL: go_mul = 1'b1;
`ifdef ALU_DIV_EN
                    F_DIVU, F_REMU: go_div = 1'b1;
`endif
                    default: ;
                endcase
            end
            OP_SHF: begin
                case (bus.func)
                    F_LSH:   sc_res = b[4] ? shr_l : shl;
                    F_ASH:   sc_res = b[4] ? shr_a : shl;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // next-state selection
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (go_mul)      state_n = S_MUL;
                    else if (go_div) state_n = S_DIV;
                    else             state_n = S_DONE;
                end
            end
            S_MUL, S_DIV: if (last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_n;
    end

    // operand latch, iteration datapath and result/flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            flg_q    <= '0;
            wr_q     <= 1'b0;
            cin_q    <= '0;
            cnt_q    <= '0;
            mcd_q    <= '0;
            mpl_q    <= '0;
            acc_q    <= '0;
`ifdef ALU_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rsel_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                cin_q <= ci;
                cnt_q <= CW'(WIDTH - 1);
                mcd_q <= a;
                mpl_q <= b;
                acc_q <= '0;
`ifdef ALU_DIV_EN
                rem_q  <= '0;
                quo_q  <= a;
                dvs_q  <= b;
                rsel_q <= (bus.func == F_REMU);
`endif
                if (!go_mul && !go_div) begin
                    result_q <= sc_res;
                    flg_q    <= sc_flg;
                    wr_q     <= sc_wr;
                end
            end
            if ((state_q == S_MUL) || (state_q == S_DIV)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (state_q == S_MUL) begin
                mcd_q <= mcd_q << 1;
                mpl_q <= mpl_q >> 1;
                acc_q <= acc_nx;
                if (last) begin
                    result_q <= acc_nx;
                    flg_q    <= cin_q;
                    wr_q     <= 1'b0;
                end
            end
`ifdef ALU_DIV_EN
            if (state_q == S_DIV) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                if (last) begin
                    result_q <= rsel_q ? rem_nx : quo_nx;
                    flg_q    <= dz ? (cin_q | 5'b00100) : cin_q;
                    wr_q     <= dz;
                end
            end
`endif
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = result_q;
    assign bus.condOut = flg_q;
    assign bus.condWr  = (state_q == S_DONE) && wr_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=16.
// Build with ALU_DIV_EN defined to cover the divider.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W = 16;

    localparam logic [3:0] ALU  = 4'b0000;
    localparam logic [3:0] SHF  = 4'b1000;
    localparam logic [3:0] ADD  = 4'b0101;
    localparam logic [3:0] SUBC = 4'b1010;
    localparam logic [3:0] CMP  = 4'b1011;
    localparam logic [3:0] MOV  = 4'b1101;
    localparam logic [3:0] MUL  = 4'b1110;
    localparam logic [3:0] DIVU = 4'b1111;
    localparam logic [3:0] REMU = 4'b1100;
    localparam logic [3:0] LSH  = 4'b0100;
    localparam logic [3:0] ASH  = 4'b0110;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] f,
                         input logic [15:0] d, input logic [15:0] s,
                         input logic [4:0] c);
        bus.oper   = o;
        bus.func   = f;
        bus.dst    = d;
        bus.src    = s;
        bus.condIn = c;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input bit inject, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            chk("busy_run", bus.busy, 1);
            if (inject && k == 5) begin
                bus.oper   = ALU;
                bus.func   = ADD;
                bus.dst    = 16'h1111;
                bus.src    = 16'h2222;
                bus.condIn = 5'b11111;
                bus.start  = 1'b1;
            end else begin
                bus.start  = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.dst    = '0;
        bus.src    = '0;
        bus.oper   = '0;
        bus.func   = '0;
        bus.condIn = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cwr", bus.condWr, 0);
        chk("rst_res", bus.result, 0);
        chk("rst_cond", bus.condOut, 0);
        reset = 1'b0;

        issue(ALU, ADD, 16'h7FFF, 16'h0001, 5'b00000);
        chk("add_done", bus.done, 1);
        chk("add_busy", bus.busy, 1);
        chk("add_res", bus.result, 16'h8000);
        chk("add_cond", bus.condOut, 5'b00100);
        chk("add_cwr", bus.condWr, 1);

        issue(ALU, MOV, 16'h5555, 16'h0F0F, 5'b00000);
        chk("donestart_done", bus.done, 0);
        chk("donestart_busy", bus.busy, 0);
        chk("add_hold", bus.result, 16'h8000);

        issue(ALU, SUBC, 16'h0000, 16'h0000, 5'b00001);
        chk("subc_done", bus.done, 1);
        chk("subc_res", bus.result, 16'hFFFF);
        chk("subc_cond", bus.condOut, 5'b00001);
        chk("subc_cwr", bus.condWr, 1);
        @(negedge clk);

        issue(ALU, CMP, 16'h0001, 16'hFFFF, 5'b00101);
        chk("cmp_res", bus.result, 16'h0001);
        chk("cmp_cond", bus.condOut, 5'b00111);
        chk("cmp_cwr", bus.condWr, 1);
        @(negedge clk);

        issue(ALU, MOV, 16'h1234, 16'hABCD, 5'b11011);
        chk("mov_res", bus.result, 16'hABCD);
        chk("mov_cond", bus.condOut, 5'b11011);
        chk("mov_cwr", bus.condWr, 0);
        @(negedge clk);

        issue(4'b0011, ADD, 16'hBEEF, 16'h0001, 5'b01010);
        chk("bad_res", bus.result, 16'hBEEF);
        chk("bad_cond", bus.condOut, 5'b01010);
        chk("bad_cwr", bus.condWr, 0);
        @(negedge clk);

        issue(ALU, MUL, 16'h0123, 16'h0045, 5'b10010);
        wait_done(1'b1, lat);
        chk("mul_lat", lat, 17);
        chk("mul_busy", bus.busy, 1);
        chk("mul_res", bus.result, 16'h4E6F);
        chk("mul_cond", bus.condOut, 5'b10010);
        chk("mul_cwr", bus.condWr, 0);
        @(negedge clk);
        chk("mul_idle", bus.busy, 0);
        chk("mul_nodup", bus.done, 0);
        chk("mul_hold", bus.result, 16'h4E6F);

`ifdef ALU_DIV_EN
        issue(ALU, DIVU, 16'd1000, 16'd7, 5'b00000);
        wait_done(1'b0, lat);
        chk("divu_lat", lat, 17);
        chk("divu_res", bus.result, 16'd142);
        chk("divu_cwr", bus.condWr, 0);
        @(negedge clk);

        issue(ALU, REMU, 16'd1000, 16'd7, 5'b00000);
        wait_done(1'b0, lat);
        chk("remu_lat", lat, 17);
        chk("remu_res", bus.result, 16'd6);
        @(negedge clk);

        issue(ALU, DIVU, 16'd1000, 16'd0, 5'b01001);
        wait_done(1'b0, lat);
        chk("div0_lat", lat, 17);
        chk("div0_res", bus.result, 16'hFFFF);
        chk("div0_cond", bus.condOut, 5'b01101);
        chk("div0_cwr", bus.condWr, 1);
        @(negedge clk);

        issue(ALU, REMU, 16'd1000, 16'd0, 5'b00000);
        wait_done(1'b0, lat);
        chk("rem0_res", bus.result, 16'd1000);
        @(negedge clk);
`else
        issue(ALU, DIVU, 16'd1000, 16'd7, 5'b00011);
        chk("nodiv_done", bus.done, 1);
        chk("nodiv_res", bus.result, 16'd1000);
        chk("nodiv_cond", bus.condOut, 5'b00011);
        chk("nodiv_cwr", bus.condWr, 0);
        @(negedge clk);
`endif

        issue(ALU, MUL, 16'h0123, 16'h0045, 5'b00000);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_res", bus.result, 0);
        chk("abort_cond", bus.condOut, 0);
        seen = 0;
        repeat (20) begin
            if (bus.done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("abort_nodone", seen, 0);

        issue(ALU, ADD, 16'h0002, 16'h0003, 5'b00000);
        chk("post_done", bus.done, 1);
        chk("post_res", bus.result, 16'h0005);
        chk("post_cond", bus.condOut, 5'b00000);
        chk("post_cwr", bus.condWr, 1);
        @(negedge clk);

        bus.oper   = ALU;
        bus.func   = ADD;
        bus.dst    = 16'h0004;
        bus.src    = 16'h0004;
        bus.start  = 1'b1;
        reset      = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        bus.start  = 1'b0;
        chk("rs_busy", bus.busy, 0);
        chk("rs_res", bus.result, 0);
        @(negedge clk);
        chk("rs_drop", bus.done, 0);

        issue(SHF, ASH, 16'h8000, 16'h001D, 5'b10101);
        chk("ash_r_res", bus.result, 16'hF000);
        chk("ash_r_cond", bus.condOut, 5'b10101);
        chk("ash_r_cwr", bus.condWr, 0);
        @(negedge clk);

        issue(SHF, LSH, 16'h0001, 16'h0004, 5'b00000);
        chk("lsh_l_res", bus.result, 16'h0010);
        chk("lsh_l_cwr", bus.condWr, 0);
        @(negedge clk);

        issue(SHF, LSH, 16'h8000, 16'h001D, 5'b00000);
        chk("lsh_r_res", bus.result, 16'h1000);
        @(negedge clk);

        issue(SHF, ASH, 16'h0003, 16'h0001, 5'b00000);
        chk("ash_l_res", bus.result, 16'h0006);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, multi-cycle arithmetic logic unit with parametrised datapath width. It is the successor to the single-cycle combinational ALU in the CS3710 processor datapath. It adds a start/done handshake, iterative unsigned multiply and optional unsigned divide/remainder, and carry-in chaining for multi-word arithmetic. The decode stage drives it; the writeback stage consumes its result and condition flags.

## Interface
- `WIDTH`, default 16: datapath width in bits; legal range 8–32.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request an operation; accepted only when `busy`=0.
- `dst`  in  WIDTH: destination operand; sampled on an accepted start.
- `src`  in  WIDTH: source operand; sampled on an accepted start.
- `oper`  in  4: major opcode; sampled on an accepted start.
- `func`  in  4: minor opcode; sampled on an accepted start.
- `condIn`  in  5: current flags {N,Z,F,L,C}; sampled on an accepted start.
- `busy`  out  1: high from the cycle after an accepted start until `done`, inclusive.
- `done`  out  1: one-cycle pulse; `result`, `condOut` and `condWr` are valid this cycle.
- `result`  out  WIDTH: operation result; held until the next `done`.
- `condOut`  out  5: new flags {N,Z,F,L,C}; held until the next `done`.
- `condWr`  out  1: flag-write enable; asserted only with `done`.

## Operation
- States: IDLE, EXEC, MUL, DIV, DONE.
- IDLE → DONE for single-cycle ops. IDLE → MUL/DIV for iterative ops. MUL/DIV → DONE after WIDTH iterations. DONE → IDLE.
- On start, operands, opcode and `condIn` are latched. Later input changes do not affect the operation.
- Opcodes with `oper`=0000, selected by `func`:
  - AND 0001, OR 0010, XOR 0011, MOV 1101 (result=`src`): `condWr`=0.
  - ADD 0101 and ADDC 0111 (adds latched C): C = carry out; F = signed overflow.
  - SUB 1001 and SUBC 1010 (subtracts latched C as borrow): C = borrow; F = signed overflow.
  - CMP 1011: result=`dst`; Z = (dst==src); L = dst<src unsigned; N = dst<src signed; C and F pass through.
  - MUL 1110: unsigned shift-add; result = low WIDTH bits of the product; `condWr`=0.
  - DIVU 1111, REMU 1100: restoring divide; result = quotient or remainder.
- Opcodes with `oper`=1000, selected by `func`:
  - LSH 0100 and ASH 0110: shift `dst` by signed `src[4:0]`; positive shifts left.
  - LSH zero-fills. ASH right shift sign-extends.
  - Flags are not written.
- ADD/ADDC/SUB/SUBC flag rules: only C and F are updated; all other bits of `condOut` copy latched `condIn`.
- Any other `oper`/`func` combination: result=`dst`, `condWr`=0.
- Divide by zero: quotient = all ones; remainder = `dst`; F=1; `condWr`=1; other flags pass through. The operation still takes the full iteration count.
- Whenever `condWr`=0, `condOut` equals latched `condIn`.
- All arithmetic is modulo 2^WIDTH. Carry and borrow are taken from bit WIDTH of a (WIDTH+1)-bit sum.

## Timing
- Reset values: `busy`=0, `done`=0, `condWr`=0, `result`=0, `condOut`=0; state = IDLE.
- Single-cycle ops: start accepted at edge N; `done`=1 during cycle N+1; `busy`=1 during cycle N+1 only.
- MUL/DIVU/REMU: `done` in cycle N+WIDTH+1; `busy` is high for cycles N+1 through N+WIDTH+1.
- `start` while `busy`=1 is ignored, with no queuing.
- `start` in the `done` cycle is ignored. The earliest back-to-back start is the cycle after `done`.
- `reset` during MUL/DIV aborts the operation: no `done` pulse; outputs return to their reset values on the next edge.
- `reset` and `start` asserted in the same cycle: reset wins and the start is dropped.

## Configuration
- `ALU_DIV_EN` defined:
  - DIVU/REMU are implemented as above.
- `ALU_DIV_EN` undefined:
  - DIVU/REMU decode as unsupported: result=`dst`, `condWr`=0.
  - Latency is 1 cycle, like the other single-cycle ops.
  - No divider registers are synthesised.

## Test plan
- Reset, then ADD with dst=0x7FFF, src=0x0001, condIn=0 → `done` at cycle 1; result=0x8000; F=1; C=0; `condWr`=1.
- SUBC with dst=0x0000, src=0x0000, condIn.C=1 → result=0xFFFF; C=1; F=0. Then CMP with dst=0x0001, src=0xFFFF → L=1, N=0, Z=0.
- MUL with dst=0x0123, src=0x0045 (WIDTH=16) → `done` exactly 17 cycles after start; result=0x4E6F. A `start` pulse at cycle 5 is ignored.
- With `ALU_DIV_EN`: DIVU 1000/7 → result 142; REMU 1000/7 → 6; DIVU by 0 → 0xFFFF with F=1. Without the macro: DIVU returns `dst` in 1 cycle with `condWr`=0.
- Assert `reset` at cycle 8 of a MUL → no `done` pulse; `busy`=0 and `result`=0 next cycle. A new ADD afterwards completes normally.
- ASH with dst=0x8000, src=-3 (0x1D) → 0xF000. LSH with dst=0x0001, src=4 → 0x0010. Both with `condWr`=0.
